// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// mem_access_stage: MEM pipeline stage with PC select, a data-memory req/ack access with timeout,
// and the MEM/WB register. All state updates on the falling edge of Clk.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] M_Jtarg,
  input  logic [31:0] M_Btarg,
  input  logic        M_Zero,
  input  logic        M_Overflow,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_busB,
  input  logic [4:0]  M_Rw,
  input  logic        M_Jump,
  input  logic        M_Branch,
  input  logic        M_MemWr,
  input  logic        M_RegWr,
  input  logic        M_MemtoReg,
  output logic [1:0]  PC_sel,
  output logic [31:0] PC_targ,
  output logic        Mem_Stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        W_RegWr,
  output logic        W_MemtoReg,
  output logic [4:0]  W_Rw,
  output logic [31:0] W_ALUout,
  output logic [31:0] W_Dout,
  output logic        Bus_Err,
  output logic        Addr_Err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            wb_regwr_q, wb_regwr_d;
  logic            wb_memtoreg_q, wb_memtoreg_d;
  logic [4:0]      wb_rw_q, wb_rw_d;
  logic [31:0]     wb_aluout_q, wb_aluout_d;
  logic [31:0]     wb_dout_q, wb_dout_d;
  logic            bus_err_q, bus_err_d;
  logic            addr_err_q, addr_err_d;

  logic mem_acc, misaligned, mem_op, timeout_hit;
  logic req_c, stall_c;

  assign mem_acc     = M_MemWr | M_MemtoReg;
  assign misaligned  = (M_ALUout[1:0] != 2'b00);
  assign mem_op      = mem_acc & ~M_Overflow & ~misaligned;
  assign timeout_hit = (state_q == S_WAIT) & ~dm_ack & (cnt_q == CNT_LAST);

  always_comb begin
    PC_sel  = 2'b00;
    PC_targ = 32'h0;
    if (M_Jump) begin
      PC_sel  = 2'b10;
      PC_targ = M_Jtarg;
    end else if (M_Branch & M_Zero) begin
      PC_sel  = 2'b01;
      PC_targ = M_Btarg;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wb_regwr_d    = wb_regwr_q;
    wb_memtoreg_d = wb_memtoreg_q;
    wb_rw_d       = wb_rw_q;
    wb_aluout_d   = wb_aluout_q;
    wb_dout_d     = wb_dout_q;
    bus_err_d     = bus_err_q;
    addr_err_d    = 1'b0;
    req_c         = 1'b0;
    stall_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_err_d = misaligned & mem_acc;
        if (mem_op) begin
          state_d    = S_WAIT;
          cnt_d      = '0;
          wb_regwr_d = 1'b0;
          req_c      = 1'b1;
          stall_c    = 1'b1;
        end else begin
          wb_regwr_d    = M_RegWr & ~M_Overflow & ~(misaligned & mem_acc);
          wb_memtoreg_d = M_MemtoReg;
          wb_rw_d       = M_Rw;
          wb_aluout_d   = M_ALUout;
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        // Stall also releases on the abort cycle so the held instruction retires instead of re-issuing.
        stall_c = ~(dm_ack | timeout_hit);
        if (dm_ack) begin
          state_d       = S_IDLE;
          wb_regwr_d    = M_RegWr;
          wb_memtoreg_d = M_MemtoReg;
          wb_rw_d       = M_Rw;
          wb_aluout_d   = M_ALUout;
          if (M_MemtoReg) begin
            wb_dout_d = dm_rdata;
          end
        end else if (timeout_hit) begin
          state_d    = S_IDLE;
          wb_regwr_d = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          wb_regwr_d = 1'b0;
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by Rst_n so the handshake is quiet for the whole reset, not just after the state clears.
  assign dm_req    = req_c & Rst_n;
  assign Mem_Stall = stall_c & Rst_n;
  assign dm_we     = req_c & Rst_n & M_MemWr;
  assign dm_addr   = M_ALUout;
  assign dm_wdata  = M_busB;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wb_regwr_q    <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_rw_q       <= 5'd0;
      wb_aluout_q   <= 32'h0;
      wb_dout_q     <= 32'h0;
      bus_err_q     <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_regwr_q    <= wb_regwr_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_rw_q       <= wb_rw_d;
      wb_aluout_q   <= wb_aluout_d;
      wb_dout_q     <= wb_dout_d;
      bus_err_q     <= bus_err_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign W_RegWr    = wb_regwr_q;
  assign W_MemtoReg = wb_memtoreg_q;
  assign W_Rw       = wb_rw_q;
  assign W_ALUout   = wb_aluout_q;
  assign W_Dout     = wb_dout_q;
  assign Bus_Err    = bus_err_q;
  assign Addr_Err   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mem_access_stage: directed cases with literal expectations plus randomized
// traffic compared every cycle against a transaction-level model of the stage.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] M_Jtarg, M_Btarg, M_ALUout, M_busB, dm_rdata;
  logic        M_Zero, M_Overflow, M_Jump, M_Branch, M_MemWr, M_RegWr, M_MemtoReg, dm_ack;
  logic [4:0]  M_Rw;
  logic [1:0]  PC_sel;
  logic [31:0] PC_targ, dm_addr, dm_wdata, W_ALUout, W_Dout;
  logic        Mem_Stall, dm_req, dm_we, W_RegWr, W_MemtoReg, Bus_Err, Addr_Err;
  logic [4:0]  W_Rw;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .M_Jtarg(M_Jtarg), .M_Btarg(M_Btarg), .M_Zero(M_Zero), .M_Overflow(M_Overflow),
    .M_ALUout(M_ALUout), .M_busB(M_busB), .M_Rw(M_Rw), .M_Jump(M_Jump),
    .M_Branch(M_Branch), .M_MemWr(M_MemWr), .M_RegWr(M_RegWr), .M_MemtoReg(M_MemtoReg),
    .PC_sel(PC_sel), .PC_targ(PC_targ), .Mem_Stall(Mem_Stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .W_RegWr(W_RegWr), .W_MemtoReg(W_MemtoReg), .W_Rw(W_Rw), .W_ALUout(W_ALUout),
    .W_Dout(W_Dout), .Bus_Err(Bus_Err), .Addr_Err(Addr_Err)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Model: whether an access is outstanding and how many wait cycles it has used so far.
  bit          m_busy;
  int          m_waited;
  logic        m_regwr, m_memtoreg, m_buserr, m_addrerr;
  logic [4:0]  m_rw;
  logic [31:0] m_alu, m_dout;
  logic        e_stall;

  // DUT values seen at the last combinational sample, for the directed literal checks.
  logic        c_stall, c_req, c_we;
  logic [1:0]  c_sel;
  logic [31:0] c_targ, c_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_busy = 0; m_waited = 0;
    m_regwr = 0; m_memtoreg = 0; m_rw = 0; m_alu = 0; m_dout = 0;
    m_buserr = 0; m_addrerr = 0;
  endtask

  // One clock: check combinational outputs, take the falling edge, then check the WB bundle.
  task automatic cycle();
    logic acc, mis, op, ereq;
    logic [1:0]  esel;
    logic [31:0] etarg;
    #1;
    acc = M_MemWr | M_MemtoReg;
    mis = (M_ALUout[1:0] != 2'b00);
    op  = acc && !M_Overflow && !mis;
    if (M_Jump) begin esel = 2'b10; etarg = M_Jtarg; end
    else if (M_Branch && M_Zero) begin esel = 2'b01; etarg = M_Btarg; end
    else begin esel = 2'b00; etarg = 32'h0; end
    ereq    = m_busy || op;
    e_stall = m_busy ? !(dm_ack || m_waited == TIMEOUT - 1) : op;
    chk("PC_sel", 32'(PC_sel), 32'(esel));
    chk("PC_targ", PC_targ, etarg);
    chk("dm_req", 32'(dm_req), 32'(ereq));
    chk("Mem_Stall", 32'(Mem_Stall), 32'(e_stall));
    if (ereq) begin
      chk("dm_we", 32'(dm_we), 32'(M_MemWr));
      chk("dm_addr", dm_addr, M_ALUout);
      chk("dm_wdata", dm_wdata, M_busB);
    end
    c_stall = Mem_Stall; c_req = dm_req; c_we = dm_we;
    c_sel = PC_sel; c_targ = PC_targ; c_wdata = dm_wdata;
    @(negedge Clk);
    if (!m_busy) begin
      m_addrerr = acc && mis;
      if (op) begin
        m_busy = 1; m_waited = 0; m_regwr = 0;
      end else begin
        m_regwr = M_RegWr && !M_Overflow && !(acc && mis);
        m_memtoreg = M_MemtoReg; m_rw = M_Rw; m_alu = M_ALUout;
      end
    end else begin
      m_addrerr = 0;
      if (dm_ack) begin
        m_busy = 0;
        m_regwr = M_RegWr; m_memtoreg = M_MemtoReg; m_rw = M_Rw; m_alu = M_ALUout;
        if (M_MemtoReg) m_dout = dm_rdata;
      end else if (m_waited == TIMEOUT - 1) begin
        m_busy = 0; m_regwr = 0; m_buserr = 1;
      end else begin
        m_waited++; m_regwr = 0;
      end
    end
    #1;
    chk("W_RegWr", 32'(W_RegWr), 32'(m_regwr));
    chk("W_MemtoReg", 32'(W_MemtoReg), 32'(m_memtoreg));
    chk("W_Rw", 32'(W_Rw), 32'(m_rw));
    chk("W_ALUout", W_ALUout, m_alu);
    chk("W_Dout", W_Dout, m_dout);
    chk("Bus_Err", 32'(Bus_Err), 32'(m_buserr));
    chk("Addr_Err", 32'(Addr_Err), 32'(m_addrerr));
  endtask

  task automatic set_instr(input logic wr, input logic ld, input logic rw_en,
                           input logic [31:0] addr, input logic [4:0] rd);
    M_MemWr = wr; M_MemtoReg = ld; M_RegWr = rw_en; M_ALUout = addr; M_Rw = rd;
    M_Overflow = 1'b0; M_Jump = 1'b0; M_Branch = 1'b0; M_Zero = 1'b0;
  endtask

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 9);
    M_MemtoReg = (k >= 4 && k <= 6);
    M_MemWr    = (k >= 7);
    M_ALUout   = $urandom;
    if ($urandom_range(0, 3) != 0) M_ALUout[1:0] = 2'b00;
    M_Overflow = ($urandom_range(0, 9) == 0);
    M_RegWr    = 1'($urandom_range(0, 1));
    M_Rw       = 5'($urandom);
    M_Jtarg    = $urandom;
    M_Btarg    = $urandom;
    M_busB     = $urandom;
    M_Jump     = 1'($urandom_range(0, 1));
    M_Branch   = 1'($urandom_range(0, 1));
    M_Zero     = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    int delay;
    bit accepted;
    Rst_n = 1'b0;
    M_Jtarg = 0; M_Btarg = 0; M_busB = 0; dm_rdata = 0; dm_ack = 0;
    set_instr(0, 0, 0, 32'h0, 5'd0);
    mdl_reset();
    #3;
    chk("reset W_RegWr", 32'(W_RegWr), 32'd0);
    chk("reset Bus_Err", 32'(Bus_Err), 32'd0);
    chk("reset Mem_Stall", 32'(Mem_Stall), 32'd0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    @(negedge Clk); #1;

    // ALU passthrough
    set_instr(0, 0, 1, 32'h1234, 5'd5);
    cycle();
    chk("alu W_RegWr", 32'(W_RegWr), 32'd1);
    chk("alu W_ALUout", W_ALUout, 32'h1234);
    chk("alu W_Rw", 32'(W_Rw), 32'd5);
    chk("alu stall", 32'(c_stall), 32'd0);

    // Load with ack in the third wait cycle
    set_instr(0, 1, 1, 32'h40, 5'd7);
    dm_rdata = 32'hDEADBEEF;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      dm_ack = (i == 3);
      cycle();
      stalls += int'(c_stall);
    end
    dm_ack = 0;
    chk("load stall cycles", 32'(stalls), 32'd3);
    chk("load W_Dout", W_Dout, 32'hDEADBEEF);
    chk("load W_MemtoReg", 32'(W_MemtoReg), 32'd1);
    chk("load W_RegWr", 32'(W_RegWr), 32'd1);

    // Misaligned store dropped, then aligned store
    set_instr(1, 0, 1, 32'h41, 5'd3);
    M_busB = 32'hA5A5A5A5;
    cycle();
    chk("misaligned dm_req", 32'(c_req), 32'd0);
    chk("misaligned Addr_Err", 32'(Addr_Err), 32'd1);
    chk("misaligned W_RegWr", 32'(W_RegWr), 32'd0);
    set_instr(1, 0, 0, 32'h44, 5'd3);
    cycle();
    chk("store dm_req", 32'(c_req), 32'd1);
    chk("store dm_we", 32'(c_we), 32'd1);
    chk("store dm_wdata", c_wdata, 32'hA5A5A5A5);
    chk("Addr_Err one pulse", 32'(Addr_Err), 32'd0);
    dm_ack = 1; cycle(); dm_ack = 0;
    chk("store keeps W_Dout", W_Dout, 32'hDEADBEEF);

    // PC select priority
    set_instr(0, 0, 0, 32'h8, 5'd1);
    M_Jtarg = 32'h11111110; M_Btarg = 32'h22222220;
    M_Jump = 1; M_Branch = 1; M_Zero = 1;
    cycle();
    chk("jump PC_sel", 32'(c_sel), 32'd2);
    chk("jump PC_targ", c_targ, 32'h11111110);
    M_Jump = 0; M_Zero = 0;
    cycle();
    chk("untaken PC_sel", 32'(c_sel), 32'd0);
    chk("untaken PC_targ", c_targ, 32'h0);
    M_Zero = 1;
    cycle();
    chk("branch PC_sel", 32'(c_sel), 32'd1);
    chk("branch PC_targ", c_targ, 32'h22222220);

    // Randomized traffic
    accepted = 1;
    delay = 0;
    for (int n = 0; n < 3000; n++) begin
      if (accepted) begin
        rand_instr();
        delay = $urandom_range(0, 18);
      end
      if (m_busy) dm_ack = (m_waited == delay);
      else dm_ack = ($urandom_range(0, 7) == 0);
      dm_rdata = $urandom;
      cycle();
      accepted = !e_stall;
    end
    for (int i = 0; i < 4 && m_busy; i++) begin
      dm_ack = 1;
      cycle();
    end
    dm_ack = 0;

    // Load that never gets an ack
    set_instr(0, 1, 1, 32'h80, 5'd9);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!c_stall) break;
      stalls++;
    end
    chk("timeout stall cycles", 32'(stalls), 32'd16);
    chk("timeout Bus_Err", 32'(Bus_Err), 32'd1);
    chk("timeout W_RegWr", 32'(W_RegWr), 32'd0);
    set_instr(0, 0, 1, 32'hABCD, 5'd4);
    cycle();
    chk("Bus_Err sticky", 32'(Bus_Err), 32'd1);

    // Reset in the middle of a wait
    set_instr(0, 1, 1, 32'h100, 5'd2);
    cycle();
    cycle();
    #2 Rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("rst dm_req", 32'(dm_req), 32'd0);
    chk("rst Mem_Stall", 32'(Mem_Stall), 32'd0);
    chk("rst W_RegWr", 32'(W_RegWr), 32'd0);
    chk("rst W_ALUout", W_ALUout, 32'h0);
    chk("rst W_Dout", W_Dout, 32'h0);
    chk("rst W_Rw", 32'(W_Rw), 32'd0);
    chk("rst Bus_Err", 32'(Bus_Err), 32'd0);
    set_instr(0, 0, 1, 32'h77, 5'd6);
    M_Overflow = 1;
    @(posedge Clk); #1 Rst_n = 1'b1;
    cycle();
    chk("overflow W_RegWr", 32'(W_RegWr), 32'd0);
    chk("overflow W_ALUout", W_ALUout, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
